// File: rtl/serial_addsub_fsm.sv
// Bit-serial adder/subtractor.
// Two WIDTH-bit operands are captured on a start request and processed one
// bit per clock, LSB first, through a single full-adder/full-subtractor cell
// with a carry/borrow flop. Completion raises done for one cycle together
// with newly loaded result, cout (carry or borrow out) and signed ovf.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last completed operation
//   RUN   | one operand bit consumed per edge; start is ignored here
//   DONE  | done pulse; start here is accepted immediately (back-to-back)
module serial_addsub_fsm #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_addsub_fsm: WIDTH must lie in 2..32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               mode_q,   mode_d;
  logic               c_q,      c_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q,   cout_d;
  logic               ovf_q,    ovf_d;

  // Single-bit arithmetic cell: current operand bits and the carry/borrow.
  logic             bit_a;
  logic             bit_b;
  logic             bit_s;
  logic             carry_add;
  logic             borrow_sub;
  logic             c_next;
  logic [WIDTH-1:0] acc_shift;
  logic             ovf_bit;

  // Full-adder / full-subtractor stage; the sum/difference bit is the same
  // XOR for both modes, only the carry/borrow equation differs.
  always_comb begin
    bit_a      = a_sh_q[0];
    bit_b      = b_sh_q[0];
    bit_s      = bit_a ^ bit_b ^ c_q;
    carry_add  = (bit_a & bit_b) | (c_q & (bit_a ^ bit_b));
    borrow_sub = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & c_q);
    c_next     = mode_q ? borrow_sub : carry_add;
    acc_shift  = {bit_s, acc_q[WIDTH-1:1]};
    // On the final bit the shift registers present the operand MSBs and
    // bit_s is the result MSB, so overflow needs no extra stored state.
    if (mode_q) begin
      ovf_bit = (bit_a != bit_b) && (bit_s != bit_a);
    end else begin
      ovf_bit = (bit_a == bit_b) && (bit_s != bit_a);
    end
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    c_d      = c_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          c_d     = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = c_next;
        acc_d  = acc_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          result_d = acc_shift;
          cout_d   = c_next;
          ovf_d    = ovf_bit;
          state_d  = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// Bench for serial_addsub_fsm: an 8-bit instance for directed vectors and
// handshake cases, a 2-bit instance for the exhaustive sweep. An arithmetic
// reference model is compared against both instances on every cycle.
module tb_serial_addsub_fsm;

  logic clk;
  logic rst_n;

  logic       start8, mode8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] result8;

  logic       start2, mode2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] result2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done2 = 0;

  serial_addsub_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
    .result(result8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub_fsm #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
    .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2),
    .result(result2), .cout(cout2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract, unsigned carry/borrow
  // from the range of the true result, signed overflow from the range of the
  // true signed result.
  function automatic void calc(input int w, input bit m, input longint ua,
                               input longint ub, input bit c,
                               output longint res, output bit co, output bit ov);
    longint lc, modv, half, full, sa, sb, sfull;
    lc    = c;
    modv  = longint'(1) << w;
    half  = modv / 2;
    full  = m ? (ua - ub - lc) : (ua + ub + lc);
    res   = ((full % modv) + modv) % modv;
    co    = m ? (ua < ub + lc) : (full >= modv);
    sa    = (ua >= half) ? ua - modv : ua;
    sb    = (ub >= half) ? ub - modv : ub;
    sfull = m ? (sa - sb - lc) : (sa + sb + lc);
    ov    = (sfull >= half) || (sfull < -half);
  endfunction

  // Model: an accepted request completes WIDTH edges later; requests seen
  // while an operation is outstanding are dropped.
  int      m8_left = 0;
  bit      m8_done = 0, m8_co = 0, m8_ov = 0, p8_co = 0, p8_ov = 0;
  bit [7:0] m8_res = 0, p8_res = 0;
  int      m2_left = 0;
  bit      m2_done = 0, m2_co = 0, m2_ov = 0, p2_co = 0, p2_ov = 0;
  bit [1:0] m2_res = 0, p2_res = 0;

  always @(posedge clk or negedge rst_n) begin
    longint r;
    bit co, ov;
    if (!rst_n) begin
      m8_left = 0; m8_done = 0; m8_res = 0; m8_co = 0; m8_ov = 0;
      m2_left = 0; m2_done = 0; m2_res = 0; m2_co = 0; m2_ov = 0;
    end else begin
      if (m8_left > 0) begin
        m8_left--;
        if (m8_left == 0) begin
          m8_done = 1; m8_res = p8_res; m8_co = p8_co; m8_ov = p8_ov;
        end
      end else begin
        m8_done = 0;
        if (start8) begin
          calc(8, mode8, longint'(a8), longint'(b8), cin8, r, co, ov);
          p8_res = r[7:0]; p8_co = co; p8_ov = ov;
          m8_left = 8;
        end
      end
      if (m2_left > 0) begin
        m2_left--;
        if (m2_left == 0) begin
          m2_done = 1; m2_res = p2_res; m2_co = p2_co; m2_ov = p2_ov;
        end
      end else begin
        m2_done = 0;
        if (start2) begin
          calc(2, mode2, longint'(a2), longint'(b2), cin2, r, co, ov);
          p2_res = r[1:0]; p2_co = co; p2_ov = ov;
          m2_left = 2;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("busy8",   busy8,   longint'(m8_left > 0));
    chk("done8",   done8,   m8_done);
    chk("result8", result8, m8_res);
    chk("cout8",   cout8,   m8_co);
    chk("ovf8",    ovf8,    m8_ov);
    chk("busy2",   busy2,   longint'(m2_left > 0));
    chk("done2",   done2,   m2_done);
    chk("result2", result2, m2_res);
    chk("cout2",   cout2,   m2_co);
    chk("ovf2",    ovf2,    m2_ov);
    if (busy8 && done8) chk("busy8_done8_exclusive", 1, 0);
    if (done2) n_done2++;
  end

  task automatic wait_done8(output int t);
    t = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic check_out8(input string name, input logic [7:0] er,
                            input bit ec, input bit eo);
    chk({name, "_result"}, result8, er);
    chk({name, "_cout"},   cout8,   ec);
    chk({name, "_ovf"},    ovf8,    eo);
  endtask

  task automatic run_op8(input string name, input bit m, input logic [7:0] a,
                         input logic [7:0] b, input bit c, input logic [7:0] er,
                         input bit ec, input bit eo);
    int t0, t1;
    @(posedge clk); #2;
    mode8 = m; a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #2;
    t0 = cyc;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = ~m; cin8 = ~c;
    wait_done8(t1);
    chk({name, "_latency"}, (t1 < 0) ? -1 : t1 - t0, 8);
    check_out8(name, er, ec, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ta, tb;
    rst_n = 1'b0;
    start8 = 0; mode8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start2 = 0; mode2 = 0; cin2 = 0; a2 = 0; b2 = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    check_out8("reset", 8'h00, 0, 0);

    run_op8("sub_5_3",   1, 8'h05, 8'h03, 0, 8'h02, 0, 0);
    run_op8("sub_0_1",   1, 8'h00, 8'h01, 0, 8'hFF, 1, 0);
    run_op8("sub_80_1",  1, 8'h80, 8'h01, 0, 8'h7F, 0, 1);
    run_op8("sub_5_5_c", 1, 8'h05, 8'h05, 1, 8'hFF, 1, 0);
    run_op8("add_7f_1",  0, 8'h7F, 8'h01, 0, 8'h80, 0, 1);
    run_op8("add_ff_1",  0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);

    // start during RUN with different operands must be ignored
    @(posedge clk); #2;
    mode8 = 1; a8 = 8'h30; b8 = 8'h10; cin8 = 0; start8 = 1;
    @(posedge clk); #2;
    t0 = cyc; start8 = 0;
    repeat (3) @(posedge clk);
    #2 mode8 = 0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; start8 = 1;
    @(posedge clk); #2 start8 = 0;
    wait_done8(ta);
    chk("ignored_start_latency", (ta < 0) ? -1 : ta - t0, 8);
    check_out8("ignored_start", 8'h20, 0, 0);

    // start held through DONE: second operation accepted back-to-back
    @(posedge clk); #2;
    mode8 = 0; a8 = 8'h12; b8 = 8'h34; cin8 = 1; start8 = 1;
    @(posedge clk); #2;
    mode8 = 1; a8 = 8'h10; b8 = 8'h20; cin8 = 0;
    wait_done8(ta);
    check_out8("b2b_first", 8'h47, 0, 0);
    @(posedge clk); #2;
    start8 = 0;
    chk("b2b_second_busy", busy8, 1);
    chk("b2b_hold_result", result8, 8'h47);
    wait_done8(tb);
    chk("b2b_done_spacing", (ta < 0 || tb < 0) ? -1 : tb - ta, 9);
    check_out8("b2b_second", 8'hF0, 1, 0);

    // asynchronous reset in the middle of an operation
    @(posedge clk); #2;
    mode8 = 0; a8 = 8'h55; b8 = 8'h22; cin8 = 0; start8 = 1;
    @(posedge clk); #2 start8 = 0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy8, 0);
    chk("midreset_done", done8, 0);
    check_out8("midreset", 8'h00, 0, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op8("after_reset_sub", 1, 8'h10, 8'h01, 0, 8'h0F, 0, 0);

    // exhaustive 2-bit sweep, back-to-back with start held high
    @(posedge clk); #2;
    for (int i = 0; i < 64; i++) begin
      mode2 = i[5]; cin2 = i[4]; a2 = i[3:2]; b2 = i[1:0]; start2 = 1'b1;
      repeat (3) @(posedge clk);
      #2;
    end
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("w2_done_count", n_done2, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub_fsm.md
Name: serial_addsub_fsm

Overview:
- Parametrised, bit-serial adder/subtractor; the sequential successor to the team's combinational full-subtractor cells.
- Captures two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, through a single full-adder/full-subtractor stage with a carry/borrow flop.
- Reports result, carry/borrow-out and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency (datapath housekeeping, checksum/offset arithmetic).

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at a rising edge when state is not RUN
- mode  input  1  0 = add (a + b + cin), 1 = subtract (a - b - cin); captured with start
- a  input  WIDTH  minuend/augend; captured with start
- b  input  WIDTH  subtrahend/addend; captured with start
- cin  input  1  carry-in (add) or borrow-in (sub); captured with start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse: result, cout and ovf are newly valid
- result  output  WIDTH  sum/difference mod 2^WIDTH
- cout  output  1  carry-out (add) or borrow-out (sub)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- The clock is one domain. rst_n is asynchronous active-low.
- States are IDLE, RUN and DONE.
- Reset (async, any state): state goes to IDLE. busy, done, result, cout, ovf and all internal registers go to 0.
- IDLE or DONE with start=1 at edge E0:
  - latch a, b, mode; seed the carry/borrow flop with cin; clear the counter; go to RUN.
  - start=0 in DONE: go to IDLE.
- RUN edges E1..E_WIDTH: one bit per edge, LSB first, from the operand shift registers.
  - add: s = ai^bi^c; c' = ai&bi | c&(ai^bi)
  - sub: d = ai^bi^c; c' = ~ai&bi | ~(ai^bi)&c
  - The result bit shifts into an internal accumulator.
  - Counter increments; at the edge where counter == WIDTH-1, go to DONE.
  - At that same edge, load result from the accumulator, set cout from the final c', and set ovf.
- ovf:
  - add: a[MSB]==b[MSB] and result[MSB]!=a[MSB]
  - sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB]
  - a, b and mode here are the captured values.
- done is high only in DONE; busy is high only in RUN; they are never high together.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH edges after the accepting edge. A 1-cycle gap before the next start is not required.
- Output stability:
  - result, cout and ovf change only at the completing edge or at reset.
  - They hold their previous values throughout RUN and after DONE until the next completion.
- start while in RUN is ignored, with no effect on the operation in progress.
- Changes on a, b, mode or cin after E0 have no effect until the next accepted start.
- Back-to-back: start=1 during DONE is accepted at the DONE→next edge. Throughput is one operation per WIDTH+1 cycles.
- Reset mid-operation abandons the operation immediately. No done pulse is produced. The next operation after reset release behaves normally.
- Arithmetic is unsigned modulo 2^WIDTH. cout=1 in sub means a < b + cin (unsigned).

Test Plan (WIDTH=8 unless noted):
- **Sub, no borrow:** mode=1, a=0x05, b=0x03, cin=0, start pulse → busy for 8 cycles, then done=1 for 1 cycle with result=0x02, cout=0, ovf=0.
- **Sub, borrow and overflow:**
  - mode=1, a=0x00, b=0x01, cin=0 → result=0xFF, cout=1, ovf=0.
  - mode=1, a=0x80, b=0x01, cin=0 → result=0x7F, cout=0, ovf=1.
  - mode=1, a=0x05, b=0x05, cin=1 → result=0xFF, cout=1.
- **Add:**
  - mode=0, a=0x7F, b=0x01, cin=0 → result=0x80, cout=0, ovf=1.
  - mode=0, a=0xFF, b=0x01, cin=0 → result=0x00, cout=1, ovf=0.
- **Handshake:**
  - Pulse start again, with different operands, 3 cycles into RUN → ignored; the original result is delivered at the original time.
  - Start held high during DONE → the second operation is accepted; done pulses exactly 9 cycles apart.
  - result holds its old value during RUN.
- **Reset mid-run:** assert rst_n=0 asynchronously after 4 RUN cycles → busy, done, result, cout and ovf are 0 immediately with no done pulse. After release, a=0x10, b=0x01, sub → result=0x0F.
- **Exhaustive check:** WIDTH=2, all a, b, cin and mode combinations (64 cases), back-to-back → result, cout and ovf match the behavioural model; done exactly 2 edges after each accept.
